pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset: clk  input  1  rising-edge clock; reset  input  1  asynchronous, active-high.
REQ-002 SHALL have input Rs_decode, 5 bits: source register A of the instruction in decode.
REQ-003 SHALL have input Rt_decode, 5 bits: source register B of the instruction in decode.
REQ-004 SHALL have inputs Rs_execute and Rt_execute, 5 bits each: source registers of the instruction in execute.
REQ-005 SHALL have inputs for execute-stage writes: write_register_execute (5 bits), register_write_execute (1 bit), memory_to_register_execute (1 bit).
REQ-006 SHALL have inputs for memory-stage writes: write_register_memory (5 bits) and register_write_memory (1 bit).
REQ-007 SHALL have inputs for writeback-stage writes: write_register_writeback (5 bits) and register_write_writeback (1 bit).
REQ-008 SHALL have input using_HI_LO_decode, 1 bit: the decode instruction reads or writes HI/LO.
REQ-009 SHALL have input div_start_execute, 1 bit: a DIV/DIVU is in execute this cycle.
REQ-010 SHALL have input HALT_execute, 1 bit: a halt is in execute.
REQ-011 SHALL have outputs stall_fetch and stall_decode, 1 bit each: hold the PC and the fetch/decode register.
REQ-012 SHALL have output clear_execute, 1 bit: drives the clear input of the decode/execute register (inserts a bubble).
REQ-013 SHALL have outputs forward_A_execute and forward_B_execute, 2 bits each, encoded as: 00 register file, 01 writeback result, 10 memory-stage ALU result.
REQ-014 SHALL have outputs hi_lo_busy (1 bit, divider running) and halted (1 bit, core stopped).

Function
REQ-015 FSM states SHALL be RUN, DIV_BUSY and HALTED, held with a 5-bit counter div_count and a 1-bit flag halt_pending.
REQ-016 forward_A_execute SHALL be combinational: 10 if register_write_memory, write_register_memory != 0 and write_register_memory == Rs_execute; else 01 if the same conditions hold for the writeback stage; else 00.
REQ-017 forward_B_execute SHALL use the same rule with Rt_execute; a memory-stage match SHALL take priority over a writeback match.
REQ-018 load_use SHALL be asserted when memory_to_register_execute, register_write_execute and write_register_execute != 0 all hold and write_register_execute equals Rs_decode or Rt_decode.
REQ-019 In RUN, load_use SHALL assert stall_fetch, stall_decode and clear_execute in the same cycle (combinational, one-cycle bubble).
REQ-020 In RUN, div_start_execute SHALL move the FSM to DIV_BUSY on the next edge and load div_count with 31.
REQ-021 In DIV_BUSY, div_count SHALL decrement every cycle and hi_lo_busy SHALL be 1; the FSM SHALL return to RUN on the edge where div_count == 0, giving exactly 32 busy cycles.
REQ-022 In DIV_BUSY, using_HI_LO_decode or load_use SHALL assert stall_fetch, stall_decode and clear_execute.
REQ-023 In DIV_BUSY, div_start_execute SHALL be ignored and SHALL NOT reload div_count.
REQ-024 In RUN, HALT_execute SHALL move the FSM to HALTED on the next edge; HALT_execute takes priority over div_start_execute in the same cycle.
REQ-025 In DIV_BUSY, HALT_execute SHALL set halt_pending; when div_count reaches 0 with halt_pending set, the FSM SHALL go to HALTED instead of RUN.
REQ-026 HALTED SHALL be terminal until reset, with stall_fetch = stall_decode = clear_execute = halted = 1 and hi_lo_busy = 0.
REQ-027 In RUN with no load_use, stall_fetch, stall_decode and clear_execute SHALL be 0.

Reset
REQ-028 Asserting reset SHALL immediately force state = RUN, div_count = 0 and halt_pending = 0.
REQ-029 While reset is high, stall_fetch, stall_decode, clear_execute, hi_lo_busy and halted SHALL be 0.
REQ-030 Forward outputs SHALL remain combinational from the inputs and are not affected by reset.
REQ-031 Reset asserted during DIV_BUSY or HALTED SHALL abort that state without completing the divide count.

Verification
REQ-032 Memory-stage write to r5, writeback write to r5, Rs_execute = 5 -> forward_A_execute = 10; with the memory write disabled -> 01; with write register 0 -> 00.
REQ-033 Load to r3 in execute with Rt_decode = 3 -> stall_fetch = stall_decode = clear_execute = 1 for exactly that cycle, and 0 the next cycle once the load has advanced.
REQ-034 div_start_execute pulse -> hi_lo_busy = 1 for 32 cycles, then 0; using_HI_LO_decode = 1 during those cycles -> stalls asserted, and deasserted on the first RUN cycle.
REQ-035 HALT_execute on the 10th DIV_BUSY cycle -> no halt until the count completes, then halted = 1 and all stalls = 1 indefinitely.
REQ-036 Reset pulse mid-DIV_BUSY (cycle 5) -> all outputs 0 immediately; a new div_start_execute then yields a full 32-cycle busy period.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Hazard control for a 5-stage pipeline: operand forwarding, load-use stalls,
// multi-cycle divider HI/LO interlock and halt sequencing.
module pipeline_hazard_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs_decode,
  input  logic [4:0] Rt_decode,
  input  logic [4:0] Rs_execute,
  input  logic [4:0] Rt_execute,
  input  logic [4:0] write_register_execute,
  input  logic       register_write_execute,
  input  logic       memory_to_register_execute,
  input  logic [4:0] write_register_memory,
  input  logic       register_write_memory,
  input  logic [4:0] write_register_writeback,
  input  logic       register_write_writeback,
  input  logic       using_HI_LO_decode,
  input  logic       div_start_execute,
  input  logic       HALT_execute,
  output logic       stall_fetch,
  output logic       stall_decode,
  output logic       clear_execute,
  output logic [1:0] forward_A_execute,
  output logic [1:0] forward_B_execute,
  output logic       hi_lo_busy,
  output logic       halted
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned FWD_W = 2;
  localparam logic [FWD_W-1:0] FWD_REG = FWD_W'(0);
  localparam logic [FWD_W-1:0] FWD_WB  = FWD_W'(1);
  localparam logic [FWD_W-1:0] FWD_MEM = FWD_W'(2);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(31);

  typedef enum logic [1:0] {RUN, DIV_BUSY, HALTED} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] div_count, div_count_next;
  logic             halt_pending, halt_pending_next;
  logic             load_use;
  logic             stall, busy, halt_flag;

  // Forwarding: memory-stage result is newer than writeback, so it wins.
  always_comb begin
    forward_A_execute = FWD_REG;
    if (register_write_memory && (write_register_memory != '0) &&
        (write_register_memory == Rs_execute))
      forward_A_execute = FWD_MEM;
    else if (register_write_writeback && (write_register_writeback != '0) &&
             (write_register_writeback == Rs_execute))
      forward_A_execute = FWD_WB;
  end

  always_comb begin
    forward_B_execute = FWD_REG;
    if (register_write_memory && (write_register_memory != '0) &&
        (write_register_memory == Rt_execute))
      forward_B_execute = FWD_MEM;
    else if (register_write_writeback && (write_register_writeback != '0) &&
             (write_register_writeback == Rt_execute))
      forward_B_execute = FWD_WB;
  end

  assign load_use = memory_to_register_execute && register_write_execute &&
                    (write_register_execute != '0) &&
                    ((write_register_execute == Rs_decode) ||
                     (write_register_execute == Rt_decode));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      div_count    <= '0;
      halt_pending <= 1'b0;
    end else begin
      state        <= state_next;
      div_count    <= div_count_next;
      halt_pending <= halt_pending_next;
    end
  end

  // Next state and stall/status decode.
  always_comb begin
    state_next        = state;
    div_count_next    = div_count;
    halt_pending_next = halt_pending;
    stall             = 1'b0;
    busy              = 1'b0;
    halt_flag         = 1'b0;
    case (state)
      RUN: begin
        stall = load_use;
        if (HALT_execute) begin
          state_next = HALTED;
        end else if (div_start_execute) begin
          state_next        = DIV_BUSY;
          div_count_next    = DIV_LAST;
          halt_pending_next = 1'b0;
        end
      end
      DIV_BUSY: begin
        busy              = 1'b1;
        stall             = using_HI_LO_decode || load_use;
        halt_pending_next = halt_pending || HALT_execute;
        div_count_next    = div_count - CNT_W'(1);
        if (div_count == '0) begin
          // A halt seen on the final busy cycle still takes effect.
          state_next        = (halt_pending || HALT_execute) ? HALTED : RUN;
          div_count_next    = '0;
          halt_pending_next = 1'b0;
        end
      end
      HALTED: begin
        stall     = 1'b1;
        halt_flag = 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  // Status outputs are held low for as long as reset is asserted.
  assign stall_fetch   = stall && !reset;
  assign stall_decode  = stall && !reset;
  assign clear_execute = stall && !reset;
  assign hi_lo_busy    = busy && !reset;
  assign halted        = halt_flag && !reset;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: table of single-cycle vectors plus
// sequences for divider, halt and reset corner cases, checked via a queue.
module tb_pipeline_hazard_controller;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e;
    logic       rw_e, m2r_e;
    logic [4:0] wr_m;
    logic       rw_m;
    logic [4:0] wr_w;
    logic       rw_w, hilo, div, halt;
  } in_t;

  typedef struct packed {
    logic       sf, sd, ce;
    logic [1:0] fa, fb;
    logic       busy, halted;
  } exp_t;

  typedef struct {
    in_t   i;
    exp_t  e;
    string name;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] Rs_decode = '0, Rt_decode = '0, Rs_execute = '0, Rt_execute = '0;
  logic [4:0] write_register_execute = '0, write_register_memory = '0;
  logic [4:0] write_register_writeback = '0;
  logic       register_write_execute = 1'b0, memory_to_register_execute = 1'b0;
  logic       register_write_memory = 1'b0, register_write_writeback = 1'b0;
  logic       using_HI_LO_decode = 1'b0, div_start_execute = 1'b0, HALT_execute = 1'b0;
  logic       stall_fetch, stall_decode, clear_execute, hi_lo_busy, halted;
  logic [1:0] forward_A_execute, forward_B_execute;

  int n_vec = 0;
  int n_err = 0;
  exp_t  exp_q[$];
  string name_q[$];
  vec_t  tbl[$];

  always #5 clk = ~clk;

  pipeline_hazard_controller dut (
    .clk(clk), .reset(reset),
    .Rs_decode(Rs_decode), .Rt_decode(Rt_decode),
    .Rs_execute(Rs_execute), .Rt_execute(Rt_execute),
    .write_register_execute(write_register_execute),
    .register_write_execute(register_write_execute),
    .memory_to_register_execute(memory_to_register_execute),
    .write_register_memory(write_register_memory),
    .register_write_memory(register_write_memory),
    .write_register_writeback(write_register_writeback),
    .register_write_writeback(register_write_writeback),
    .using_HI_LO_decode(using_HI_LO_decode),
    .div_start_execute(div_start_execute),
    .HALT_execute(HALT_execute),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .clear_execute(clear_execute),
    .forward_A_execute(forward_A_execute), .forward_B_execute(forward_B_execute),
    .hi_lo_busy(hi_lo_busy), .halted(halted)
  );

  function automatic in_t idle();
    in_t v = '0;
    return v;
  endfunction

  function automatic exp_t ex(logic s, logic [1:0] fa, logic [1:0] fb, logic busy, logic hl);
    exp_t e;
    e.sf = s; e.sd = s; e.ce = s;
    e.fa = fa; e.fb = fb; e.busy = busy; e.halted = hl;
    return e;
  endfunction

  function automatic in_t fw(logic [4:0] rs_e, logic [4:0] rt_e, logic [4:0] wr_m,
                             logic rw_m, logic [4:0] wr_w, logic rw_w);
    in_t v = '0;
    v.rs_e = rs_e; v.rt_e = rt_e; v.wr_m = wr_m; v.rw_m = rw_m;
    v.wr_w = wr_w; v.rw_w = rw_w;
    return v;
  endfunction

  function automatic in_t ld(logic [4:0] rs_d, logic [4:0] rt_d, logic [4:0] wr_e,
                             logic rw_e, logic m2r_e);
    in_t v = '0;
    v.rs_d = rs_d; v.rt_d = rt_d; v.wr_e = wr_e; v.rw_e = rw_e; v.m2r_e = m2r_e;
    return v;
  endfunction

  task automatic add(input in_t v, input exp_t e, input string name);
    vec_t t;
    t.i = v; t.e = e; t.name = name;
    tbl.push_back(t);
  endtask

  task automatic check();
    exp_t  e;
    exp_t  got;
    string name;
    e    = exp_q.pop_front();
    name = name_q.pop_front();
    got.sf = stall_fetch; got.sd = stall_decode; got.ce = clear_execute;
    got.fa = forward_A_execute; got.fb = forward_B_execute;
    got.busy = hi_lo_busy; got.halted = halted;
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s: got sf/sd/ce=%b%b%b fa=%b fb=%b busy=%b halted=%b, expected sf/sd/ce=%b%b%b fa=%b fb=%b busy=%b halted=%b",
               name, got.sf, got.sd, got.ce, got.fa, got.fb, got.busy, got.halted,
               e.sf, e.sd, e.ce, e.fa, e.fb, e.busy, e.halted);
    end
  endtask

  // Drive one cycle of inputs just after the edge, check mid-cycle.
  task automatic apply(input in_t v, input exp_t e, input string name);
    reset = v.rst;
    Rs_decode = v.rs_d; Rt_decode = v.rt_d;
    Rs_execute = v.rs_e; Rt_execute = v.rt_e;
    write_register_execute = v.wr_e; register_write_execute = v.rw_e;
    memory_to_register_execute = v.m2r_e;
    write_register_memory = v.wr_m; register_write_memory = v.rw_m;
    write_register_writeback = v.wr_w; register_write_writeback = v.rw_w;
    using_HI_LO_decode = v.hilo; div_start_execute = v.div; HALT_execute = v.halt;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_t v;

    v = ld(5'd3, 5'd3, 5'd3, 1'b1, 1'b1);
    v.rst = 1'b1; v.rs_e = 5'd5; v.wr_m = 5'd5; v.rw_m = 1'b1;
    add(v, ex(1'b0, 2'b10, 2'b00, 1'b0, 1'b0), "reset_outputs_low_fwd_live");
    add(idle(), ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "idle_run");
    add(fw(5'd5, 5'd0, 5'd5, 1'b1, 5'd5, 1'b1), ex(1'b0, 2'b10, 2'b00, 1'b0, 1'b0), "fwdA_mem_priority");
    add(fw(5'd5, 5'd0, 5'd5, 1'b0, 5'd5, 1'b1), ex(1'b0, 2'b01, 2'b00, 1'b0, 1'b0), "fwdA_wb");
    add(fw(5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1), ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "fwdA_r0");
    add(fw(5'd7, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1), ex(1'b0, 2'b10, 2'b10, 1'b0, 1'b0), "fwdAB_mem");
    add(fw(5'd2, 5'd9, 5'd2, 1'b1, 5'd9, 1'b1), ex(1'b0, 2'b10, 2'b01, 1'b0, 1'b0), "fwdA_mem_B_wb");
    add(fw(5'd9, 5'd9, 5'd4, 1'b1, 5'd9, 1'b0), ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "fwd_no_write");
    add(ld(5'd0, 5'd3, 5'd3, 1'b1, 1'b1), ex(1'b1, 2'b00, 2'b00, 1'b0, 1'b0), "load_use_rt");
    add(ld(5'd0, 5'd3, 5'd6, 1'b1, 1'b0), ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "load_advanced");
    add(ld(5'd0, 5'd0, 5'd0, 1'b1, 1'b1), ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "load_r0");
    add(ld(5'd8, 5'd0, 5'd8, 1'b0, 1'b1), ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "load_no_regwrite");
    add(ld(5'd8, 5'd0, 5'd8, 1'b1, 1'b0), ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "alu_no_stall");
    add(ld(5'd12, 5'd1, 5'd12, 1'b1, 1'b1), ex(1'b1, 2'b00, 2'b00, 1'b0, 1'b0), "load_use_rs");
    v = idle(); v.hilo = 1'b1;
    add(v, ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "hilo_in_run");

    @(posedge clk);
    #1;
    foreach (tbl[k]) apply(tbl[k].i, tbl[k].e, tbl[k].name);

    // Divide: HI/LO stalls, ignored restarts, load-use during busy.
    v = idle(); v.div = 1'b1;
    apply(v, ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "div_start");
    for (int i = 0; i < 32; i++) begin
      v = idle();
      v.div  = (i % 4 == 0);
      v.hilo = (i < 30);
      if (i == 30) v = ld(5'd4, 5'd0, 5'd4, 1'b1, 1'b1);
      apply(v, ex(i != 31, 2'b00, 2'b00, 1'b1, 1'b0), $sformatf("div_busy_%0d", i));
    end
    v = idle(); v.hilo = 1'b1;
    apply(v, ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "div_done_run");

    // Halt during divide waits for the count to finish.
    v = idle(); v.div = 1'b1;
    apply(v, ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "div2_start");
    for (int i = 0; i < 32; i++) begin
      v = idle(); v.halt = (i == 9);
      apply(v, ex(1'b0, 2'b00, 2'b00, 1'b1, 1'b0), $sformatf("div2_busy_%0d", i));
    end
    for (int k = 0; k < 4; k++) begin
      v = idle(); v.div = (k == 1);
      apply(v, ex(1'b1, 2'b00, 2'b00, 1'b0, 1'b1), $sformatf("halted_%0d", k));
    end
    v = idle(); v.rst = 1'b1;
    apply(v, ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "reset_from_halted");
    apply(idle(), ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "run_after_reset");

    // Halt beats a simultaneous divide start.
    v = idle(); v.halt = 1'b1; v.div = 1'b1;
    apply(v, ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "halt_and_div");
    apply(idle(), ex(1'b1, 2'b00, 2'b00, 1'b0, 1'b1), "halt_priority");
    v = idle(); v.rst = 1'b1;
    apply(v, ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "reset_from_halted2");

    // Reset in the middle of a divide aborts it; a new divide runs in full.
    v = idle(); v.div = 1'b1;
    apply(v, ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "div3_start");
    for (int i = 0; i < 5; i++) begin
      v = idle(); v.hilo = 1'b1;
      apply(v, ex(1'b1, 2'b00, 2'b00, 1'b1, 1'b0), $sformatf("div3_busy_%0d", i));
    end
    v = idle(); v.rst = 1'b1; v.hilo = 1'b1;
    apply(v, ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "reset_mid_div");
    v = idle(); v.div = 1'b1;
    apply(v, ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "div4_start");
    for (int i = 0; i < 32; i++)
      apply(idle(), ex(1'b0, 2'b00, 2'b00, 1'b1, 1'b0), $sformatf("div4_busy_%0d", i));
    apply(idle(), ex(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "div4_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
